// File: rtl/qram_access_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : qram_access_sequencer
// Summary  : Shares the QRAM_inSDRAM command port between requesters A and B;
//            runs power-up init, periodic auto-refresh and ACT/RW/PRE timing.
// Revision : 1.0 - initial release
// ============================================================================
module qram_access_sequencer #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 8,
    parameter int T_RCD          = 2,
    parameter int T_CAS          = 2,
    parameter int T_RP           = 2,
    parameter int T_RFC          = 4,
    parameter int REFRESH_PERIOD = 390,
    parameter int INIT_WAIT      = 100
) (
    input  logic              Crystal50Mhz1,
    input  logic              ResetLow,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic              WeA,
    input  logic              WeB,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WDataA,
    input  logic [DATA_W-1:0] WDataB,
    output logic              AckA,
    output logic              AckB,
    output logic [DATA_W-1:0] RData,
    output logic [2:0]        MemCmd,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    output logic              InitDone
);

    localparam logic [2:0] c_CMD_NOP   = 3'b000;
    localparam logic [2:0] c_CMD_ACT   = 3'b001;
    localparam logic [2:0] c_CMD_READ  = 3'b010;
    localparam logic [2:0] c_CMD_WRITE = 3'b011;
    localparam logic [2:0] c_CMD_PRE   = 3'b100;
    localparam logic [2:0] c_CMD_REF   = 3'b101;

    localparam int c_M1      = (INIT_WAIT - 1 > T_RP) ? INIT_WAIT - 1 : T_RP;
    localparam int c_M2      = (c_M1 > T_RFC) ? c_M1 : T_RFC;
    localparam int c_M3      = (c_M2 > T_RCD) ? c_M2 : T_RCD;
    localparam int c_CNT_MAX = (c_M3 > T_CAS) ? c_M3 : T_CAS;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_REF_W   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    localparam logic [c_CNT_W-1:0] c_LD_INIT    = c_CNT_W'(INIT_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_LD_RP_INIT = c_CNT_W'(T_RP);
    localparam logic [c_CNT_W-1:0] c_LD_RP      = c_CNT_W'(T_RP - 1);
    localparam logic [c_CNT_W-1:0] c_LD_RFC     = c_CNT_W'(T_RFC - 1);
    localparam logic [c_CNT_W-1:0] c_LD_RCD     = c_CNT_W'(T_RCD - 1);
    localparam logic [c_CNT_W-1:0] c_LD_CAS     = c_CNT_W'(T_CAS - 1);
    localparam logic [c_REF_W-1:0] c_REF_LAST   = c_REF_W'(REFRESH_PERIOD - 1);

    typedef enum logic [3:0] {
        INIT_NOP  = 4'd0,
        INIT_PRE  = 4'd1,
        INIT_REF1 = 4'd2,
        INIT_REF2 = 4'd3,
        IDLE      = 4'd4,
        ACT       = 4'd5,
        RCD_WAIT  = 4'd6,
        ACCESS    = 4'd7,
        CAS_WAIT  = 4'd8,
        PRE       = 4'd9,
        RP_WAIT   = 4'd10,
        REF       = 4'd11,
        RFC_WAIT  = 4'd12
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_REF_W-1:0]  r_refcnt;
    logic                r_refpend;
    logic                r_last_b;
    logic                r_gnt_b;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_memcmd;
    logic [ADDR_W-1:0]   r_memaddr;
    logic [DATA_W-1:0]   r_memwdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_acka;
    logic                r_ackb;
    logic                r_initdone;
    logic                w_pick_b;
    logic                w_ref_wrap;

    // B wins only when A is idle, or when both ask and A was served last
    assign w_pick_b   = ReqB & (~ReqA | ~r_last_b);
    assign w_ref_wrap = r_initdone & (r_refcnt == c_REF_LAST);

    always_ff @(posedge Crystal50Mhz1) begin
        if (!ResetLow) begin
            r_state    <= INIT_NOP;
            r_cnt      <= c_LD_INIT;
            r_refcnt   <= '0;
            r_refpend  <= 1'b0;
            r_last_b   <= 1'b1;
            r_gnt_b    <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_memcmd   <= c_CMD_NOP;
            r_memaddr  <= '0;
            r_memwdata <= '0;
            r_rdata    <= '0;
            r_acka     <= 1'b0;
            r_ackb     <= 1'b0;
            r_initdone <= 1'b0;
        end else begin
            r_memcmd <= c_CMD_NOP;
            r_acka   <= 1'b0;
            r_ackb   <= 1'b0;

            if (r_initdone) begin
                if (w_ref_wrap) r_refcnt <= '0;
                else            r_refcnt <= r_refcnt + 1'b1;
            end

            case (r_state)
                INIT_NOP: begin
                    if (r_cnt == '0) begin
                        r_state  <= INIT_PRE;
                        r_memcmd <= c_CMD_PRE;
                        r_cnt    <= c_LD_RP_INIT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                INIT_PRE: begin
                    if (r_cnt == '0) begin
                        r_state  <= INIT_REF1;
                        r_memcmd <= c_CMD_REF;
                        r_cnt    <= c_LD_RFC;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                INIT_REF1: begin
                    if (r_cnt == '0) begin
                        r_state  <= INIT_REF2;
                        r_memcmd <= c_CMD_REF;
                        r_cnt    <= c_LD_RFC;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                INIT_REF2: begin
                    if (r_cnt == '0) begin
                        r_state    <= IDLE;
                        r_initdone <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (r_refpend) begin
                        r_refpend <= 1'b0;
                        r_state   <= REF;
                        r_memcmd  <= c_CMD_REF;
                        r_cnt     <= c_LD_RFC;
                    end else if (ReqA || ReqB) begin
                        r_gnt_b   <= w_pick_b;
                        r_last_b  <= w_pick_b;
                        r_we      <= w_pick_b ? WeB : WeA;
                        r_wdata   <= w_pick_b ? WDataB : WDataA;
                        r_memaddr <= w_pick_b ? AddrB : AddrA;
                        r_memcmd  <= c_CMD_ACT;
                        r_cnt     <= c_LD_RCD;
                        r_state   <= ACT;
                    end
                end
                ACT, RCD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ACCESS;
                        if (r_we) begin
                            r_memcmd   <= c_CMD_WRITE;
                            r_memwdata <= r_wdata;
                            r_acka     <= ~r_gnt_b;
                            r_ackb     <= r_gnt_b;
                        end else begin
                            r_memcmd <= c_CMD_READ;
                        end
                    end else begin
                        r_state <= RCD_WAIT;
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_state  <= PRE;
                        r_memcmd <= c_CMD_PRE;
                        r_cnt    <= c_LD_RP;
                    end else begin
                        r_state <= CAS_WAIT;
                        r_cnt   <= c_LD_CAS;
                    end
                end
                CAS_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata  <= MemRData;
                        r_acka   <= ~r_gnt_b;
                        r_ackb   <= r_gnt_b;
                        r_state  <= PRE;
                        r_memcmd <= c_CMD_PRE;
                        r_cnt    <= c_LD_RP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PRE, RP_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= RP_WAIT;
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                REF, RFC_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= RFC_WAIT;
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= INIT_NOP;
                    r_cnt   <= c_LD_INIT;
                end
            endcase

            // Placed after the FSM so a fresh expiry outranks the IDLE clear
            if (w_ref_wrap) r_refpend <= 1'b1;
        end
    end

    assign AckA     = r_acka;
    assign AckB     = r_ackb;
    assign RData    = r_rdata;
    assign MemCmd   = r_memcmd;
    assign MemAddr  = r_memaddr;
    assign MemWData = r_memwdata;
    assign InitDone = r_initdone;

endmodule
`default_nettype wire
